ws2812_rx: RTL and testbench
============================

# ws2812_rx

WS2812 single-wire LED protocol receiver. It decodes the NRZ pulse stream produced by `ws2812` (or any WS2812-compatible source) into 24-bit pixels. It also forwards all later pixels downstream, the same way a real LED in a chain does. It serves as a loopback checker for the `ws2812` transmitter in the SoC top, and as the front end of a future IO-mapped LED-chain monitor.

## Interface
Parameters:
- `CLK_HZ`, 27_000_000: clock frequency; all timing thresholds are derived from it.
- `T_THRESH_NS`, 600: high-time threshold. High time ≥ threshold decodes as 1; shorter decodes as 0.
- `T_MAXHI_NS`, 2000: high time above this is a protocol error.
- `T_RESET_US`, 50: low time at or above this is a latch/reset (frame end).

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `din_i`, in, 1: asynchronous WS2812 data line.
- `pix_valid_o`, out, 1: one-cycle pulse when the first 24 bits of a frame have been captured.
- `r_o`, out, 8: captured red byte; held until the next capture.
- `g_o`, out, 8: captured green byte; held until the next capture.
- `b_o`, out, 8: captured blue byte; held until the next capture.
- `frame_o`, out, 1: one-cycle pulse on detection of a reset/latch interval.
- `err_o`, out, 1: one-cycle pulse on a protocol error.
- `dout_i`: not used. The forwarded stream is on `dout_o`.
- `dout_o`, out, 1: forwarded data line. It is 0 except in `PASS`.

## Operation
- `din_i` passes through a 2-FF synchronizer, giving `din_s`. Edge detection uses a third register.
- Derived constants, computed with integer arithmetic and truncated:
  - `THRESH = CLK_HZ/1e6*T_THRESH_NS/1000`. At 27 MHz this is 16.
  - `MAXHI = 54` at 27 MHz, derived the same way from `T_MAXHI_NS`.
  - `RESET = CLK_HZ/1e6*T_RESET_US`. At 27 MHz this is 1350.
  - The counter is `$clog2(RESET+1)` bits wide and saturates at `RESET`.
- The shift register is 24 bits wide, MSB first, with wire order G, R, B. Bits [23:16] map to `g_o`, [15:8] to `r_o`, [7:0] to `b_o`.
- The bit counter is 5 bits wide.

State machine:
- **IDLE**
  - Rising `din_s` → HIGH, with cnt=1.
  - Line low → stay.
- **HIGH**
  - cnt increments each cycle while `din_s`=1.
  - cnt reaches `MAXHI` → `err_o` pulse, clear bits → WAITRST.
  - Falling edge → shift in (cnt ≥ `THRESH`), bitcnt++, cnt=1.
  - If bitcnt becomes 24: latch `r/g/b`, pulse `pix_valid_o`, go to PASS.
  - Otherwise go to LOW.
- **LOW**
  - cnt increments while `din_s`=0.
  - Rising edge → HIGH, with cnt=1.
  - cnt reaches `RESET` → `frame_o` pulse, plus `err_o` because bitcnt≠0 here. Discard the partial pixel and go to IDLE. Outputs `r/g/b` are unchanged.
- **PASS**
  - `dout_o` = `din_s`.
  - cnt counts consecutive low cycles and clears on high.
  - cnt reaches `RESET` → `frame_o` pulse, bitcnt=0 → IDLE.
  - No high-time checking is done in PASS.
- **WAITRST**
  - Ignore input until low persists for `RESET` cycles.
  - Then `frame_o` pulse → IDLE. No second `err_o` is raised.

Boundary rules:
- High time exactly `THRESH` decodes as 1. `THRESH`-1 decodes as 0.
- A frame_end with bitcnt=0 in LOW cannot occur, because LOW is entered only after a bit has been shifted in.
- IDLE does not count. A long low in IDLE produces no `frame_o`.
- Simultaneous falling edge and cnt==`MAXHI` in HIGH: the error takes priority.
- `rst` mid-frame returns the block to IDLE and clears the shift register, bitcnt, cnt, `dout_o` and all pulses. `r/g/b` reset to 0.

## Timing
- Reset values: all outputs 0; state IDLE.
- Input latency is 2 cycles of synchronizer plus 1 cycle of edge register.
- `pix_valid_o` is asserted in the cycle after the registered falling edge of bit 23. `r/g/b` are valid in that same cycle.
- `dout_o` lags `din_i` by 3 cycles in PASS, with constant delay and no pulse reshaping.
- `frame_o` fires exactly `RESET` low cycles after the last registered falling edge.
- Each pulse output lasts exactly one cycle. Pulses never repeat without a new event.

## Structure
- Package `ws2812_pkg` holds:
  - the timing constants `T0H_NS`=400, `T1H_NS`=800, `TBIT_NS`=1250, `T_THRESH_NS`, `T_RESET_US`;
  - a function that converts ns to cycles;
  - the state enum `ws2812_rx_state_e`.
- The existing `ws2812` transmitter is switched to the same package so that the transmitter and receiver cannot drift apart.
- Sub-module `sync2`: a generic 2-FF synchronizer, reused for future external inputs.

## Test plan
1. Send G=0x12, R=0x34, B=0x56 using 11-cycle highs for 0 and 22-cycle highs for 1, with a 34-cycle bit period, then hold low for 1350 cycles. Expect one `pix_valid_o` with `r_o`=0x34, `g_o`=0x12, `b_o`=0x56, then one `frame_o`, and no `err_o`.
2. Loopback: write the IO_RGB register with r=0xAA, g=0x55, b=0x0F. Expect the `ws2812` output into `ws2812_rx` to yield the same bytes and one `frame_o`.
3. Send two pixels back to back: 0x00FF00, then 0xFFFFFF. Expect only the first pixel to be captured. `dout_o` reproduces the second pixel's 24 pulses, delayed by 3 cycles. Expect `frame_o` after the latch interval.
4. Send 10 bits, then hold low for 1350 cycles. Expect `err_o` and `frame_o` in the same cycle, no `pix_valid_o`, and `r/g/b` unchanged.
5. Hold the line high for 60 cycles mid-frame. Expect `err_o` at high cycle 54. Further edges are ignored until 1350 low cycles, then `frame_o`. The next valid pixel decodes correctly.
6. Assert `rst` after 12 bits. Expect all outputs 0, and a following complete pixel decodes correctly.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared WS2812 timing constants, ns-to-cycle conversion and receiver state encoding,
// used by both the transmitter and the receiver so their timings cannot drift apart.
package ws2812_pkg;

    localparam int T0H_NS      = 400;
    localparam int T1H_NS      = 800;
    localparam int TBIT_NS     = 1250;
    localparam int T_THRESH_NS = 600;
    localparam int T_RESET_US  = 50;

    // Whole MHz first, then scale, so 27 MHz * 600 ns truncates to 16 cycles.
    function automatic int ns_to_cycles(input int clk_hz, input int ns);
        return (clk_hz / 1_000_000) * ns / 1000;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        PASS,
        WAITRST
    } ws2812_rx_state_e;

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous inputs; 2-cycle latency.
module sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ws2812_rx.sv
// WS2812 receiver: decodes the first 24-bit GRB pixel of a frame and forwards the rest on dout_o.
// Input path is 3 cycles (2 sync + edge register); no backpressure, outputs are one-cycle pulses.
module ws2812_rx #(
    parameter int CLK_HZ      = 27_000_000,
    parameter int T_THRESH_NS = ws2812_pkg::T_THRESH_NS,
    parameter int T_MAXHI_NS  = 2000,
    parameter int T_RESET_US  = ws2812_pkg::T_RESET_US
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din_i,
    output logic       pix_valid_o,
    output logic [7:0] r_o,
    output logic [7:0] g_o,
    output logic [7:0] b_o,
    output logic       frame_o,
    output logic       err_o,
    output logic       dout_o
);

    import ws2812_pkg::*;

    localparam int RESET = ns_to_cycles(CLK_HZ, T_RESET_US * 1000);
    localparam int CW    = $clog2(RESET + 1);

    localparam logic [CW-1:0] THRESH_C = CW'(ns_to_cycles(CLK_HZ, T_THRESH_NS));
    localparam logic [CW-1:0] MAXHI_C  = CW'(ns_to_cycles(CLK_HZ, T_MAXHI_NS));
    localparam logic [CW-1:0] RESET_C  = CW'(RESET);
    localparam logic [CW-1:0] ONE_C    = CW'(1);

    logic             din_s;
    logic             din_d;
    ws2812_rx_state_e state;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic [4:0]       bitcnt;
    logic [23:0]      shreg;
    logic [23:0]      sh_next;

    sync2 #(.WIDTH(1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (din_i),
        .q   (din_s)
    );

    assign cnt_inc = (cnt == RESET_C) ? cnt : cnt + ONE_C;
    assign sh_next = {shreg[22:0], (cnt >= THRESH_C)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            din_d       <= 1'b0;
            cnt         <= '0;
            bitcnt      <= '0;
            shreg       <= '0;
            r_o         <= '0;
            g_o         <= '0;
            b_o         <= '0;
            pix_valid_o <= 1'b0;
            frame_o     <= 1'b0;
            err_o       <= 1'b0;
            dout_o      <= 1'b0;
        end else begin
            din_d       <= din_s;
            pix_valid_o <= 1'b0;
            frame_o     <= 1'b0;
            err_o       <= 1'b0;
            dout_o      <= (state == PASS) && din_s;

            case (state)
                IDLE: begin
                    if (din_s && !din_d) begin
                        cnt   <= ONE_C;
                        state <= HIGH;
                    end
                end
                HIGH: begin
                    // Over-long high wins even when the falling edge lands on the same cycle.
                    if (cnt == MAXHI_C) begin
                        err_o  <= 1'b1;
                        shreg  <= '0;
                        bitcnt <= '0;
                        cnt    <= '0;
                        state  <= WAITRST;
                    end else if (!din_s) begin
                        shreg  <= sh_next;
                        bitcnt <= bitcnt + 5'd1;
                        cnt    <= ONE_C;
                        if (bitcnt == 5'd23) begin
                            g_o         <= sh_next[23:16];
                            r_o         <= sh_next[15:8];
                            b_o         <= sh_next[7:0];
                            pix_valid_o <= 1'b1;
                            state       <= PASS;
                        end else begin
                            state <= LOW;
                        end
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                LOW: begin
                    if (cnt == RESET_C) begin
                        frame_o <= 1'b1;
                        err_o   <= (bitcnt != 5'd0);
                        shreg   <= '0;
                        bitcnt  <= '0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else if (din_s) begin
                        cnt   <= ONE_C;
                        state <= HIGH;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                PASS, WAITRST: begin
                    // Both only wait for a full latch interval of low; pulses in between are not decoded.
                    if (cnt == RESET_C) begin
                        frame_o <= 1'b1;
                        shreg   <= '0;
                        bitcnt  <= '0;
                        cnt     <= '0;
                        state   <= IDLE;
                    end else if (din_s) begin
                        cnt <= '0;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_rx.sv
// Scoreboarded bench for ws2812_rx: directed pulse trains, expected events queued ahead of the monitor.
module tb_ws2812_rx;

    localparam int RESET = 1350;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       din_i = 1'b0;
    logic       pix_valid_o;
    logic [7:0] r_o;
    logic [7:0] g_o;
    logic [7:0] b_o;
    logic       frame_o;
    logic       err_o;
    logic       dout_o;

    always #5 clk = ~clk;

    ws2812_rx dut (
        .clk         (clk),
        .rst         (rst),
        .din_i       (din_i),
        .pix_valid_o (pix_valid_o),
        .r_o         (r_o),
        .g_o         (g_o),
        .b_o         (b_o),
        .frame_o     (frame_o),
        .err_o       (err_o),
        .dout_o      (dout_o)
    );

    typedef struct {
        logic        pix;
        logic        frame;
        logic        err;
        logic [23:0] rgb;   // {r, g, b}
        int          cyc;   // 0 = arrival cycle not checked
    } ev_t;

    ev_t  expq[$];
    int   checks     = 0;
    int   errors     = 0;
    int   cyc        = 0;
    int   h1         = 22;
    int   h0         = 11;
    int   per        = 34;
    int   last_fall  = 0;
    int   rise_at    = 0;
    int   dmode      = 0;   // 0 off, 1 dout must equal din 3 cycles earlier, 2 dout must be 0
    int   dout_rises = 0;
    logic [2:0] hist = '0;
    logic dout_prev  = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic void push(input logic p, input logic f, input logic e,
                                 input logic [23:0] rgb, input int c);
        ev_t ev;
        ev.pix   = p;
        ev.frame = f;
        ev.err   = e;
        ev.rgb   = rgb;
        ev.cyc   = c;
        expq.push_back(ev);
    endfunction

    // Monitor: sampled on the falling edge, away from the DUT's active edge.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst && (pix_valid_o || frame_o || err_o)) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got pix=%0b frame=%0b err=%0b at cycle %0d, expected none",
                             pix_valid_o, frame_o, err_o, cyc);
                end else begin
                    e = expq.pop_front();
                    check("event_kind", {29'd0, pix_valid_o, frame_o, err_o}, {29'd0, e.pix, e.frame, e.err});
                    if (e.pix) check("pixel_rgb", {8'd0, r_o, g_o, b_o}, {8'd0, e.rgb});
                    if (e.cyc != 0) check("event_cycle", cyc, e.cyc);
                end
            end
            if (dmode == 1) begin
                check("dout_delay", {31'd0, dout_o}, {31'd0, hist[2]});
                if (dout_o && !dout_prev) dout_rises++;
            end else if (dmode == 2) begin
                check("dout_idle", {31'd0, dout_o}, 32'd0);
            end
            dout_prev = dout_o;
            hist      = {hist[1:0], din_i};
        end
    end

    task automatic hold(input logic v, input int n);
        din_i = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        int h = b ? h1 : h0;
        rise_at = cyc;
        hold(1'b1, h);
        last_fall = cyc;
        hold(1'b0, per - h);
    endtask

    // Sends word[23] downwards, nbits bits in total.
    task automatic send_word(input logic [23:0] word, input int nbits);
        for (int i = 23; i > 23 - nbits; i--) send_bit(word[i]);
    endtask

    // Falling edge driven in cycle c reaches the state machine 3 cycles later; frame_o follows RESET cycles on.
    task automatic pixel_and_latch(input logic [23:0] grb, input logic [23:0] rgb);
        push(1'b1, 1'b0, 1'b0, rgb, 0);
        send_word(grb, 24);
        push(1'b0, 1'b1, 1'b0, 24'd0, last_fall + RESET + 3);
        hold(1'b0, RESET + 20);
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pix_valid", {31'd0, pix_valid_o}, 32'd0);
        check("reset_frame",     {31'd0, frame_o},     32'd0);
        check("reset_err",       {31'd0, err_o},       32'd0);
        check("reset_dout",      {31'd0, dout_o},      32'd0);
        check("reset_rgb",       {8'd0, r_o, g_o, b_o}, 32'd0);
        rst = 1'b0;
        hold(1'b0, 5);

        // Basic pixel, G=12 R=34 B=56; line must never be forwarded outside PASS.
        dmode = 2;
        pixel_and_latch(24'h123456, 24'h341256);
        dmode = 0;

        // Two pixels back to back: second one forwarded, not captured.
        push(1'b1, 1'b0, 1'b0, 24'hFF0000, 0);
        send_word(24'h00FF00, 24);
        dmode      = 1;
        dout_rises = 0;
        send_word(24'hFFFFFF, 24);
        hold(1'b0, 10);
        dmode = 0;
        check("dout_pulse_count", dout_rises, 24);
        push(1'b0, 1'b1, 1'b0, 24'd0, last_fall + RESET + 3);
        hold(1'b0, RESET);

        // Truncated frame: 10 bits then latch gives frame and err together, pixel untouched.
        send_word(24'hABCDEF, 10);
        push(1'b0, 1'b1, 1'b1, 24'd0, last_fall + RESET + 3);
        hold(1'b0, RESET + 20);
        check("rgb_after_short_frame", {8'd0, r_o, g_o, b_o}, {8'd0, 24'hFF0000});

        // Stuck-high mid-frame: err 57 cycles after the driven rise, later pulses ignored.
        send_word(24'hF0F0F0, 5);
        rise_at = cyc;
        push(1'b0, 1'b0, 1'b1, 24'd0, rise_at + 57);
        hold(1'b1, 60);
        hold(1'b0, 20);
        send_word(24'hFFFFFF, 3);
        push(1'b0, 1'b1, 1'b0, 24'd0, last_fall + RESET + 3);
        hold(1'b0, RESET + 20);
        pixel_and_latch(24'hA53CC3, 24'h3CA5C3);

        // Reset after 12 bits clears everything including the held pixel.
        send_word(24'h123456, 12);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midrst_rgb",   {8'd0, r_o, g_o, b_o}, 32'd0);
        check("midrst_flags", {28'd0, pix_valid_o, frame_o, err_o, dout_o}, 32'd0);
        rst = 1'b0;
        hold(1'b0, 5);
        pixel_and_latch(24'h0FF081, 24'hF00F81);

        // Threshold boundary: 16-cycle high is a 1, 15-cycle high is a 0.
        h1 = 16; h0 = 15;
        pixel_and_latch(24'h5AC381, 24'hC35A81);

        // Longest legal high (53 cycles) must decode as 1 without error.
        h1 = 53; h0 = 2; per = 70;
        pixel_and_latch(24'hFF0001, 24'h00FF01);
        h1 = 22; h0 = 11; per = 34;

        hold(1'b0, 50);
        check("scoreboard_drained", expq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
